// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a pending-write scoreboard and a sequential bulk-clear engine.
// Optional write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [WIDTH-1:0]  data_wr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] addr1_r,
  input  logic [ADDR_W-1:0] addr2_r,
  output logic [WIDTH-1:0]  out1_r,
  output logic [WIDTH-1:0]  out2_r,
  output logic              pend1_r,
  output logic              pend2_r,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  logic [WIDTH-1:0]  regs_reg [DEPTH];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  wr_hit, rsv_hit, clr_hit;
  logic              is_idle, wr_ok, rsv_ok;

  assign is_idle = (state_reg == ST_IDLE);
  assign wr_ok   = enable && write_en && is_idle && (addr_wr != '0);
  assign rsv_ok  = enable && rsv_en && is_idle && (rsv_addr != '0);

  // R0 is never written, so its slot stays at its reset value of zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      if (gi == 0) begin : g_r0
        assign wr_hit[gi]  = 1'b0;
        assign rsv_hit[gi] = 1'b0;
        assign clr_hit[gi] = 1'b0;
      end else begin : g_rn
        assign wr_hit[gi]  = wr_ok && (addr_wr == ADDR_W'(gi));
        assign rsv_hit[gi] = rsv_ok && (rsv_addr == ADDR_W'(gi));
        assign clr_hit[gi] = enable && (state_reg == ST_CLEAR) && (index_reg == ADDR_W'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
      pend_reg <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (clr_hit[i]) begin
          regs_reg[i] <= '0;
          pend_reg[i] <= 1'b0;
        end else begin
          if (wr_hit[i]) begin
            regs_reg[i] <= data_wr;
            pend_reg[i] <= 1'b0;
          end
          // A same-cycle reservation overrides the write's pending clear.
          if (rsv_hit[i]) pend_reg[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable && clr_req) begin
          state_next = ST_CLEAR;
          index_next = FIRST_IDX;
        end
      end
      ST_CLEAR: begin
        if (enable) begin
          if (index_reg == LAST_IDX) begin
            state_next = ST_DONE;
            index_next = FIRST_IDX;
          end else begin
            index_next = index_reg + 1'b1;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      index_reg <= FIRST_IDX;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  assign clr_busy = (state_reg == ST_CLEAR);
  assign clr_done = (state_reg == ST_DONE);

`ifdef RF_BYPASS_EN
  logic byp1, byp2, rsv_same;
  assign byp1     = !rst && wr_ok && (addr1_r == addr_wr);
  assign byp2     = !rst && wr_ok && (addr2_r == addr_wr);
  assign rsv_same = rsv_ok && (rsv_addr == addr_wr);
  assign out1_r   = byp1 ? data_wr  : regs_reg[addr1_r];
  assign out2_r   = byp2 ? data_wr  : regs_reg[addr2_r];
  assign pend1_r  = byp1 ? rsv_same : pend_reg[addr1_r];
  assign pend2_r  = byp2 ? rsv_same : pend_reg[addr2_r];
`else
  assign out1_r  = regs_reg[addr1_r];
  assign out2_r  = regs_reg[addr2_r];
  assign pend1_r = pend_reg[addr1_r];
  assign pend2_r = pend_reg[addr2_r];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model compared every cycle plus directed literal checks.
module tb_regfile_sb;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk, rst, enable, write_en, rsv_en, clr_req;
  logic [ADDR_W-1:0] addr_wr, rsv_addr, addr1_r, addr2_r;
  logic [WIDTH-1:0]  data_wr, out1_r, out2_r;
  logic              pend1_r, pend2_r, clr_busy, clr_done;

  regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .write_en(write_en),
    .addr_wr(addr_wr), .data_wr(data_wr), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .addr1_r(addr1_r), .addr2_r(addr2_r), .out1_r(out1_r), .out2_r(out2_r),
    .pend1_r(pend1_r), .pend2_r(pend2_r), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, pending flags, and clear progress.
  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_pend [DEPTH];
  bit               m_clearing, m_done, cmp_on;
  int               m_next;

  initial cmp_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_clearing = 1'b0;
      m_done     = 1'b0;
      m_next     = 1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_clearing) begin
      if (enable) begin
        m_regs[m_next] = '0;
        m_pend[m_next] = 1'b0;
        if (m_next == DEPTH - 1) begin
          m_clearing = 1'b0;
          m_done     = 1'b1;
        end else begin
          m_next = m_next + 1;
        end
      end
    end else if (enable) begin
      if (write_en && addr_wr != 0) begin
        m_regs[addr_wr] = data_wr;
        m_pend[addr_wr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_next     = 1;
      end
    end
  end

  function automatic bit m_byp(input logic [ADDR_W-1:0] a);
    return BYP && !rst && !m_clearing && !m_done && enable && write_en
           && (addr_wr != 0) && (a == addr_wr);
  endfunction

  function automatic logic [WIDTH-1:0] m_out(input logic [ADDR_W-1:0] a);
    if (m_byp(a)) return data_wr;
    return m_regs[a];
  endfunction

  function automatic bit m_pnd(input logic [ADDR_W-1:0] a);
    if (m_byp(a)) return rsv_en && (rsv_addr == addr_wr);
    return m_pend[a];
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      check("out1_r", out1_r, m_out(addr1_r));
      check("out2_r", out2_r, m_out(addr2_r));
      check("pend1_r", pend1_r, m_pnd(addr1_r));
      check("pend2_r", pend2_r, m_pnd(addr2_r));
      check("clr_busy", clr_busy, m_clearing);
      check("clr_done", clr_done, m_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    write_en = 1'b1; addr_wr = a; data_wr = d;
    step();
    write_en = 1'b0;
  endtask

  // Runs one clear sequence; enable is dropped for hold_len iterations starting at hold_at.
  // A write, a reserve and a second clr_req are injected while busy and must all be dropped.
  task automatic run_clear(input int hold_at, input int hold_len, output int busy_cnt, output bit done_seen);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_seen = 1'b0;
    for (int it = 0; it < 60 && !done_seen; it++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_seen = 1'b1;
      end else begin
        enable   = !(it >= hold_at && it < hold_at + hold_len);
        write_en = (it == 1); addr_wr = 2; data_wr = 8'hEE;
        rsv_en   = (it == 2); rsv_addr = 3;
        clr_req  = (it == 1);
        step();
      end
    end
    write_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    // DONE must fall back to IDLE even with enable low.
    enable = 1'b0;
    step();
    check("done_to_idle_busy", clr_busy, 1'b0);
    check("done_pulse_len", clr_done, 1'b0);
    enable = 1'b1;
  endtask

  int  busy_cnt;
  bit  done_seen;

  initial begin
    rst = 1'b1; enable = 1'b1; write_en = 1'b0; addr_wr = '0; data_wr = '0;
    rsv_en = 1'b0; rsv_addr = '0; addr1_r = '0; addr2_r = '0; clr_req = 1'b0;
    step(); step();
    rst = 1'b0;
    cmp_on = 1'b1;
    addr1_r = 3; addr2_r = 7;
    #1;
    check("reset_out1", out1_r, 8'h00);
    check("reset_busy", clr_busy, 1'b0);

    wr(1, 8'hAA);
    wr(3, 8'h55);
    addr1_r = 1; addr2_r = 3;
    #1;
    check("read_r1", out1_r, 8'hAA);
    check("read_r3", out2_r, 8'h55);
    wr(0, 8'hFF);
    addr1_r = 0;
    #1;
    check("read_r0", out1_r, 8'h00);
    check("pend_r0", pend1_r, 1'b0);

    rsv_en = 1'b1; rsv_addr = 5;
    step();
    rsv_en = 1'b0;
    addr1_r = 5;
    #1;
    check("rsv_r5_pend", pend1_r, 1'b1);
    wr(5, 8'h12);
    #1;
    check("wr_r5_out", out1_r, 8'h12);
    check("wr_r5_pend", pend1_r, 1'b0);
    rsv_en = 1'b1; rsv_addr = 6; write_en = 1'b1; addr_wr = 6; data_wr = 8'h77;
    step();
    rsv_en = 1'b0; write_en = 1'b0;
    addr2_r = 6;
    #1;
    check("wr_rsv_r6_out", out2_r, 8'h77);
    check("wr_rsv_r6_pend", pend2_r, 1'b1);

    for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), WIDTH'(i * 17));
    rsv_en = 1'b1; rsv_addr = 4;
    step();
    rsv_en = 1'b0;
    run_clear(0, 0, busy_cnt, done_seen);
    check("clear_busy_cycles", busy_cnt, 7);
    check("clear_done_seen", done_seen, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      addr1_r = ADDR_W'(i);
      #1;
      check("cleared_out", out1_r, 8'h00);
      check("cleared_pend", pend1_r, 1'b0);
    end

    for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), WIDTH'(i * 17 + 1));
    run_clear(3, 3, busy_cnt, done_seen);
    check("held_busy_cycles", busy_cnt, 10);
    check("held_done_seen", done_seen, 1'b1);

    addr1_r = 2;
    write_en = 1'b1; addr_wr = 2; data_wr = 8'h3C;
    #1;
    check("bypass_same_cycle", out1_r, BYP ? 8'h3C : 8'h00);
    step();
    write_en = 1'b0;
    #1;
    check("write_next_cycle", out1_r, 8'h3C);

    wr(7, 8'h99);
    addr1_r = 7; addr2_r = 2;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step(); step();
    check("midclear_r7_old", out1_r, 8'h99);
    check("midclear_r2_zero", out2_r, 8'h00);
    check("midclear_busy", clr_busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out1", out1_r, 8'h00);
    check("async_rst_busy", clr_busy, 1'b0);
    check("async_rst_done", clr_done, 1'b0);
    step();
    rst = 1'b0;

    wr(1, 8'h11);
    wr(2, 8'h22);
    addr1_r = 1; addr2_r = 2;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    check("restart_r1_cleared", out1_r, 8'h00);
    check("restart_r2_kept", out2_r, 8'h22);
    check("restart_busy", clr_busy, 1'b1);
    for (int k = 0; k < 20 && !clr_done; k++) step();
    check("restart_done", clr_done, 1'b1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/one-write register file with per-register pending-write scoreboard and a sequential bulk-clear engine. Successor to the 8x8 register file in the datapath: same R0-hardwired-zero convention, generalised width/depth, adds hazard tracking for the pipelined core and a context-clear sequence driven by the control unit. Sits between decode (reads, reservations) and writeback (writes).

## Interface
- WIDTH, 8: data width in bits (>=1)
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers (ADDR_W >= 1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  global advance; 0 = write, reserve and clear engine frozen; reads unaffected
- write_en  in  1  write strobe (writeback)
- addr_wr  in  ADDR_W  write address
- data_wr  in  WIDTH  write data
- rsv_en  in  1  mark register as pending (decode issues an op targeting it)
- rsv_addr  in  ADDR_W  register to reserve
- addr1_r, addr2_r  in  ADDR_W  read addresses
- out1_r, out2_r  out  WIDTH  read data, combinational from addresses
- pend1_r, pend2_r  out  1  pending flag of addressed register, combinational
- clr_req  in  1  start bulk clear (level sampled in IDLE)
- clr_busy  out  1  high while clear sequence runs
- clr_done  out  1  one-cycle pulse at sequence end

## Operation
- Storage: regs[1..DEPTH-1] of WIDTH bits; R0 not stored, reads 0, pending always 0; writes/reserves to address 0 discarded.
- Write: on edge with enable && write_en && addr_wr!=0 && state==IDLE: regs[addr_wr] <= data_wr; pend[addr_wr] <= 0.
- Reserve: on edge with enable && rsv_en && rsv_addr!=0 && state==IDLE: pend[rsv_addr] <= 1.
- Write and reserve same register same cycle: data written, pending ends 1 (reserve wins).
- Write to non-pending register legal; pending bit stays 0.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when enable && clr_req; index <= 1.
  - CLEAR: each enabled edge regs[index] <= 0, pend[index] <= 0, index++; after index DEPTH-1 cleared -> DONE.
  - DONE: clr_done=1 for one cycle, -> IDLE unconditionally (regardless of enable).
  - clr_req outside IDLE ignored; write_en/rsv_en during CLEAR/DONE dropped, not queued.
  - enable=0 in CLEAR holds state and index.
- Reads always serviced, including mid-clear (registers not yet cleared return old values).

## Timing
- Reset (async assert, any cycle, including mid-clear): all regs 0, all pend 0, state IDLE, index 1, clr_busy 0, clr_done 0; out/pend outputs follow (0 for all addresses).
- Read latency 0 (combinational); written value visible on out*_r after the write edge.
- Clear sequence: clr_req sampled at edge N -> clr_busy high from N to edge N+DEPTH-1 (DEPTH-1 CLEAR cycles), clr_done high during cycle after last clear, clr_busy 0 in DONE. Total DEPTH cycles from request to IDLE with enable held 1.
- clr_busy = (state==CLEAR); clr_done = (state==DONE); both registered-state decodes, glitch-free.
- DEPTH=2 edge case: exactly one CLEAR cycle.

## Configuration
- RF_BYPASS_EN defined: write-to-read bypass. When a write qualifies this cycle and addr*_r == addr_wr (nonzero), out*_r = data_wr and pend*_r = 0, unless rsv_en to same address qualifies this cycle (then pend*_r = 1). Reserve is never bypassed otherwise.
- RF_BYPASS_EN undefined: out*_r/pend*_r reflect stored state only; new data visible one cycle later.

## Test plan
- Reset with WIDTH=8, ADDR_W=3: rst=1 mid-operation -> out1_r=00, out2_r=00, pend*=0, clr_busy=0 immediately (before next edge).
- Write R1=AA, R3=55, then read 1/3 -> out1_r=AA, out2_r=55; write FF to R0 -> reading R0 gives 00, pend 0.
- Reserve R5, read R5 -> pend=1; write R5=12 -> pend=0, out=12; same-cycle write+reserve R6 -> out=data, pend=1.
- Load R1..R7 nonzero, pulse clr_req -> clr_busy 7 cycles, clr_done one cycle, all reads 00; write_en during busy has no effect; enable=0 for 3 cycles mid-clear -> total 10 busy cycles.
- With RF_BYPASS_EN: write R2=3C with addr1_r=2 -> out1_r=3C same cycle; without macro -> old value same cycle, 3C next.
- rst asserted at CLEAR index 4 -> FSM IDLE, all regs 00, next clr_req restarts at index 1.
